wb_stage: RTL
=============

Name: wb_stage

Overview:
- Final pipeline stage. Consumes the memory stage's retire bus.
- Commits general-register writes and CSR writes, and raises exception/ertn flush pulses toward the CSR unit and upstream stages.
- Drives the debug trace interface and publishes a forwarding/blocking bus to decode.
- Maintains a wrapping retired-instruction counter for performance monitoring.

Parameters:
- EXC_NUM, 6, number of exception flag bits carried on the retire bus. Bit order is fixed in the package: INT=0, ADEF=1, ALE=2, SYS=3, BRK=4, INE=5.
- MS_TO_WS_BUS_WD, 150+EXC_NUM, width of the retire bus from the memory stage.

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous, active-low reset
- ms_to_ws_valid  input  1  memory stage holds a valid instruction
- ms_to_ws_bus  input  MS_TO_WS_BUS_WD  MSB to LSB: {csr_we, csr_wnum[13:0], csr_wmask[31:0], csr_wdata[31:0], inst_ertn, exc_flgs[EXC_NUM-1:0], gr_we, dest[4:0], final_result[31:0], pc[31:0]}
- ws_allowin  output  1  stage can accept an instruction
- rf_we / rf_waddr / rf_wdata  output  1/5/32  register-file write port
- csr_we / csr_wnum / csr_wmask / csr_wdata  output  1/14/32/32  CSR write port
- wb_exc  output  1  exception commit pulse
- wb_ertn  output  1  ertn commit pulse
- wb_ecode / wb_esubcode  output  6/9  exception cause
- wb_pc / wb_badv  output  32/32  exception PC and bad virtual address
- ws_fwd_blk_bus  output  38  {rf_we, dest[4:0], final_result[31:0]} for decode forwarding
- ws_csr_blk_bus  output  16  {csr_we & ws_valid, inst_ertn & ws_valid, csr_wnum}
- debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  output  32/4/5/32  trace
- perf_retire_cnt  output  32  retired-instruction count

Behaviour:
- Reset (resetn low, asynchronous):
  - ws_valid=0, bus register=0, perf_retire_cnt=0.
  - Every output that is qualified by ws_valid is therefore 0. wb_pc, wb_badv and the debug data fields read 0.
  - Reset asserted mid-instruction drops that instruction; nothing commits.
- Handshake:
  - ws_ready_go=1. ws_allowin = !ws_valid || ws_ready_go.
  - On a rising clk edge with ws_allowin: ws_valid <= ms_to_ws_valid.
  - Bus register loads only when ms_to_ws_valid && ws_allowin.
  - Latency: one cycle from memory-stage handoff to commit.
- Commit qualification:
  - exc_any = |exc_flgs.
  - rf_we = ws_valid & gr_we & ~exc_any.
  - csr_we = ws_valid & csr_we_f & ~exc_any.
  - wb_exc = ws_valid & exc_any.
  - wb_ertn = ws_valid & inst_ertn & ~exc_any.
  - wb_exc and wb_ertn are single-cycle pulses per instruction and are never both 1.
- Flush:
  - In the cycle after wb_exc or wb_ertn, ws_valid clears unless a new valid is accepted that same edge.
  - Upstream suppression of wrong-path instructions is the memory stage's duty; this stage commits whatever arrives valid.
- Exception priority (lowest set index wins): INT > ADEF > ALE > SYS > BRK > INE. ecode and badv by winning cause:
  - INT: ecode 0x00, badv=0.
  - ADEF: ecode 0x08, esubcode 0, badv=pc.
  - ALE: ecode 0x09, badv=final_result.
  - SYS: ecode 0x0B, badv=0.
  - BRK: ecode 0x0C, badv=0.
  - INE: ecode 0x0D, badv=0.
  - esubcode=0 for all causes.
  - wb_pc=pc whenever ws_valid.
- Debug trace:
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_pc = ws_valid ? pc : 0.
  - Other debug fields mirror the rf write port.
- Counter:
  - perf_retire_cnt increments by 1 on every cycle with ws_valid & ~exc_any (ertn counts).
  - Wraps from 0xFFFFFFFF to 0.
- Forward bus: the rf_we field is already valid-qualified, so decode compares dest only when that bit is 1.

Decomposition:
- Package / mycpu.h holds:
  - EXC_NUM, the EXC_FLG_* bit indices, and the ECODE_* constants.
  - MS_TO_WS_BUS_WD, WS_FWD_BLK_BUS_WD=38 and WS_CSR_BLK_BUS_WD=16.
- One sub-module, wb_exc_encode: combinational priority encoder mapping {exc_flgs, pc, final_result} to {ecode, esubcode, badv}. The stage body holds the registers, qualification and counter.

Test Plan:
- Plain retire: valid bus with gr_we=1, dest=5, result=0x1234_5678, pc=0x1C00_0010 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, debug_wb_rf_we=4'hF, perf_retire_cnt 0->1.
- ALE exception: exc_flgs=6'b000100, gr_we=1, result=0x8000_0003 -> wb_exc=1 for one cycle, ecode=0x09, badv=0x80000003, rf_we=0, csr_we=0, counter unchanged.
- Simultaneous ADEF+SYS+INE (flags 6'b101010) with pc=0x1C00_0041 -> ecode=0x08, badv=0x1C000041.
- Ertn with csr_we=1, wnum=0x0 -> wb_ertn=1, wb_exc=0, csr_we=1. Back-to-back valid retires: 3 consecutive instructions -> 3 rf writes on consecutive cycles, counter=3.
- Wrap and reset: preload counter to 0xFFFFFFFF, retire one instruction -> 0. Assert resetn=0 mid-cycle while ws_valid=1 -> rf_we and wb_exc drop immediately with no clock edge, counter=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage: retire-bus layout,
// exception flag indices, exception codes and the bus widths seen by decode.
package wb_stage_pkg;

    localparam int EXC_NUM            = 6;
    localparam int MS_TO_WS_BUS_WD    = 150 + EXC_NUM;
    localparam int WS_FWD_BLK_BUS_WD  = 38;
    localparam int WS_CSR_BLK_BUS_WD  = 16;

    localparam int EXC_FLG_INT  = 0;
    localparam int EXC_FLG_ADEF = 1;
    localparam int EXC_FLG_ALE  = 2;
    localparam int EXC_FLG_SYS  = 3;
    localparam int EXC_FLG_BRK  = 4;
    localparam int EXC_FLG_INE  = 5;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Winning exception after priority resolution.
    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_INT,
        CAUSE_ADEF,
        CAUSE_ALE,
        CAUSE_SYS,
        CAUSE_BRK,
        CAUSE_INE
    } exc_cause_e;

    // Field order matches the memory stage's packing, MSB first.
    typedef struct packed {
        logic               csr_we;
        logic [13:0]        csr_wnum;
        logic [31:0]        csr_wmask;
        logic [31:0]        csr_wdata;
        logic               inst_ertn;
        logic [EXC_NUM-1:0] exc_flgs;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        final_result;
        logic [31:0]        pc;
    } ws_bus_t;

endpackage

// File: rtl/wb_exc_encode.sv
// Priority encoder turning raw exception flags into the cause code, subcode
// and bad virtual address reported to the CSR unit.
module wb_exc_encode
    import wb_stage_pkg::*;
(
    input  logic [EXC_NUM-1:0] exc_flgs,
    input  logic [31:0]        pc,
    input  logic [31:0]        final_result,
    output logic [5:0]         ecode,
    output logic [8:0]         esubcode,
    output logic [31:0]        badv
);

    exc_cause_e cause;

    // Lowest flag index has the highest priority.
    always_comb begin
        cause = CAUSE_NONE;
        if (exc_flgs[EXC_FLG_INT])
            cause = CAUSE_INT;
        else if (exc_flgs[EXC_FLG_ADEF])
            cause = CAUSE_ADEF;
        else if (exc_flgs[EXC_FLG_ALE])
            cause = CAUSE_ALE;
        else if (exc_flgs[EXC_FLG_SYS])
            cause = CAUSE_SYS;
        else if (exc_flgs[EXC_FLG_BRK])
            cause = CAUSE_BRK;
        else if (exc_flgs[EXC_FLG_INE])
            cause = CAUSE_INE;
    end

    // Only address faults report a bad address: fetch faults the PC,
    // misaligned accesses the computed data address.
    always_comb begin
        ecode    = ECODE_INT;
        esubcode = '0;
        badv     = '0;
        case (cause)
            CAUSE_INT:  ecode = ECODE_INT;
            CAUSE_ADEF: begin
                ecode = ECODE_ADEF;
                badv  = pc;
            end
            CAUSE_ALE:  begin
                ecode = ECODE_ALE;
                badv  = final_result;
            end
            CAUSE_SYS:  ecode = ECODE_SYS;
            CAUSE_BRK:  ecode = ECODE_BRK;
            CAUSE_INE:  ecode = ECODE_INE;
            default:    ecode = ECODE_INT;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the retire bus, commits GR/CSR writes, raises
// exception/ertn pulses, drives the trace port and counts retired instructions.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    output logic                         ws_allowin,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic                         csr_we,
    output logic [13:0]                  csr_wnum,
    output logic [31:0]                  csr_wmask,
    output logic [31:0]                  csr_wdata,
    output logic                         wb_exc,
    output logic                         wb_ertn,
    output logic [5:0]                   wb_ecode,
    output logic [8:0]                   wb_esubcode,
    output logic [31:0]                  wb_pc,
    output logic [31:0]                  wb_badv,
    output logic [WS_FWD_BLK_BUS_WD-1:0] ws_fwd_blk_bus,
    output logic [WS_CSR_BLK_BUS_WD-1:0] ws_csr_blk_bus,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata,
    output logic [31:0]                  perf_retire_cnt
);

    localparam logic WS_READY_GO = 1'b1;

    logic    ws_valid;
    ws_bus_t bus_q;
    logic    exc_any;
    logic [31:0] retire_cnt_q;

    assign ws_allowin = !ws_valid || WS_READY_GO;

    // A flush needs no extra logic: the stage always accepts, so ws_valid
    // simply follows whatever the memory stage offers on the next edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ws_valid <= 1'b0;
        else if (ws_allowin)
            ws_valid <= ms_to_ws_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bus_q <= '0;
        else if (ms_to_ws_valid && ws_allowin)
            bus_q <= ws_bus_t'(ms_to_ws_bus);
    end

    assign exc_any = |bus_q.exc_flgs;

    // Ertn retires normally; only excepting instructions are left uncounted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            retire_cnt_q <= '0;
        else if (ws_valid && !exc_any)
            retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign perf_retire_cnt = retire_cnt_q;

    assign rf_we    = ws_valid & bus_q.gr_we & ~exc_any;
    assign rf_waddr = bus_q.dest;
    assign rf_wdata = bus_q.final_result;

    assign csr_we    = ws_valid & bus_q.csr_we & ~exc_any;
    assign csr_wnum  = bus_q.csr_wnum;
    assign csr_wmask = bus_q.csr_wmask;
    assign csr_wdata = bus_q.csr_wdata;

    assign wb_exc  = ws_valid & exc_any;
    assign wb_ertn = ws_valid & bus_q.inst_ertn & ~exc_any;
    assign wb_pc   = ws_valid ? bus_q.pc : 32'd0;

    wb_exc_encode u_exc_encode (
        .exc_flgs     (bus_q.exc_flgs),
        .pc           (bus_q.pc),
        .final_result (bus_q.final_result),
        .ecode        (wb_ecode),
        .esubcode     (wb_esubcode),
        .badv         (wb_badv)
    );

    // Decode may only compare dest when the leading rf_we bit is set.
    assign ws_fwd_blk_bus = {rf_we, bus_q.dest, bus_q.final_result};
    assign ws_csr_blk_bus = {bus_q.csr_we & ws_valid, bus_q.inst_ertn & ws_valid, bus_q.csr_wnum};

    assign debug_wb_pc       = ws_valid ? bus_q.pc : 32'd0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
